// File: rtl/shift_unit_arbiter_if.sv
// Request/result bundle for the shared shift unit.
// Two requester ports plus one result port.
interface shift_unit_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_data;
  logic [4:0]  a_shamt;
  logic [1:0]  a_op;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_data;
  logic [4:0]  b_shamt;
  logic [1:0]  b_op;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_id;

  modport master (
    output a_valid, a_data, a_shamt, a_op,
    output b_valid, b_data, b_shamt, b_op,
    output res_ready,
    input  a_ready, b_ready,
    input  res_valid, res_data, res_id
  );

  modport slave (
    input  a_valid, a_data, a_shamt, a_op,
    input  b_valid, b_data, b_shamt, b_op,
    input  res_ready,
    output a_ready, b_ready,
    output res_valid, res_data, res_id
  );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit shifter
// between two requesters, with a one-entry result register.
module shift_unit_arbiter (
  input logic             clk,
  input logic             rst_n,
  shift_unit_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        prio;
  logic        can_accept;
  logic        grant_a;
  logic        grant_b;
  logic        accept;
  logic [31:0] sel_data;
  logic [4:0]  sel_shamt;
  logic [1:0]  sel_op;
  logic [31:0] shifted;
  logic [31:0] res_data;
  logic        res_id;

  // Log shifter: stages of 16/8/4/2/1
  function automatic logic [31:0] shift32(
    input logic [31:0] d,
    input logic [4:0]  s,
    input logic [1:0]  op
  );
    logic [31:0] v;
    v = d;
    for (int k = 4; k >= 0; k--) begin
      if (s[k]) begin
        unique case (op)
          2'b00: v = v << (1 << k);
          2'b01: v = v >> (1 << k);
          2'b10: v = $signed(v) >>> (1 << k);
          2'b11: v = (v >> (1 << k))
                   | (v << (32 - (1 << k)));
        endcase
      end
    end
    return v;
  endfunction

  // Grant selection and operand mux
  always_comb begin
    can_accept = (state == EMPTY) || bus.res_ready;
    grant_a = rst_n && can_accept && bus.a_valid
            && (!bus.b_valid || !prio);
    grant_b = rst_n && can_accept && bus.b_valid
            && (!bus.a_valid || prio);
    accept = grant_a || grant_b;
    sel_data  = grant_b ? bus.b_data  : bus.a_data;
    sel_shamt = grant_b ? bus.b_shamt : bus.a_shamt;
    sel_op    = grant_b ? bus.b_op    : bus.a_op;
    shifted   = shift32(sel_data, sel_shamt, sel_op);
  end

  // Next-state for the result register occupancy
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL: begin
        if (bus.res_ready && !accept)
          state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Result payload and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_id   <= 1'b0;
      prio     <= 1'b0;
    end else if (accept) begin
      res_data <= shifted;
      res_id   <= grant_b;
      prio     <= !grant_b;
    end
  end

  assign bus.a_ready   = grant_a;
  assign bus.b_ready   = grant_b;
  assign bus.res_valid = (state == FULL);
  assign bus.res_data  = res_data;
  assign bus.res_id    = res_id;
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Bench for shift_unit_arbiter: reference model
// plus directed vectors with literal expectations.
module tb_shift_unit_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  shift_unit_arbiter_if bus();

  shift_unit_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Spec-level shift: wide-word arithmetic
  function automatic logic [31:0] ref_shift(
    input logic [31:0] d,
    input logic [4:0]  s,
    input logic [1:0]  op
  );
    logic [63:0] w;
    case (op)
      2'b00: w = {32'b0, d} << s;
      2'b01: w = {32'b0, d} >> s;
      2'b10: w = {{32{d[31]}}, d} >> s;
      default: w = {d, d} >> s;
    endcase
    return w[31:0];
  endfunction

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               name, got, exp);
    end
  endtask

  // Model state
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic        m_id    = 1'b0;
  logic        m_prio  = 1'b0;
  logic        e_ga;
  logic        e_gb;

  // Who the model says wins this cycle
  always_comb begin
    e_ga = 1'b0;
    e_gb = 1'b0;
    if (rst_n && (!m_valid || bus.res_ready)) begin
      if (bus.a_valid && bus.b_valid) begin
        e_ga = !m_prio;
        e_gb = m_prio;
      end else begin
        e_ga = bus.a_valid;
        e_gb = bus.b_valid;
      end
    end
  end

  // Model update at each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_id    <= 1'b0;
      m_prio  <= 1'b0;
    end else if (e_ga || e_gb) begin
      m_valid <= 1'b1;
      m_id    <= e_gb;
      m_prio  <= ~e_gb;
      m_data  <= e_gb
        ? ref_shift(bus.b_data, bus.b_shamt, bus.b_op)
        : ref_shift(bus.a_data, bus.a_shamt, bus.a_op);
    end else if (bus.res_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    check("a_ready", 32'(bus.a_ready), 32'(e_ga));
    check("b_ready", 32'(bus.b_ready), 32'(e_gb));
    check("res_valid", 32'(bus.res_valid), 32'(m_valid));
    if (m_valid) begin
      check("res_data", bus.res_data, m_data);
      check("res_id", 32'(bus.res_id), 32'(m_id));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [31:0] d,
                       input logic [4:0] s, input logic [1:0] op);
    bus.a_valid = v;
    bus.a_data  = d;
    bus.a_shamt = s;
    bus.a_op    = op;
  endtask

  task automatic set_b(input logic v, input logic [31:0] d,
                       input logic [4:0] s, input logic [1:0] op);
    bus.b_valid = v;
    bus.b_data  = d;
    bus.b_shamt = s;
    bus.b_op    = op;
  endtask

  logic [31:0] ids [4];

  initial begin
    ids = '{32'd0, 32'd1, 32'd0, 32'd1};
    set_a(1'b0, '0, '0, '0);
    set_b(1'b0, '0, '0, '0);
    bus.res_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    check("rst_valid", 32'(bus.res_valid), 32'd0);
    check("rst_data", bus.res_data, 32'd0);
    check("rst_id", 32'(bus.res_id), 32'd0);

    // SRA on port A
    set_a(1'b1, 32'h8000_00F0, 5'd4, 2'b10);
    step();
    set_a(1'b0, '0, '0, '0);
    check("sra_data", bus.res_data, 32'hF800_000F);
    check("sra_id", 32'(bus.res_id), 32'd0);
    check("sra_valid", 32'(bus.res_valid), 32'd1);
    step();
    check("drain_valid", 32'(bus.res_valid), 32'd0);

    // SLL then ROR on port B
    set_b(1'b1, 32'h0000_0001, 5'd31, 2'b00);
    step();
    check("sll_data", bus.res_data, 32'h8000_0000);
    check("sll_id", 32'(bus.res_id), 32'd1);
    set_b(1'b1, 32'h0000_0001, 5'd1, 2'b11);
    step();
    check("ror_data", bus.res_data, 32'h8000_0000);
    set_b(1'b0, '0, '0, '0);
    step();

    // Contention with no backpressure
    set_a(1'b1, 32'h0000_00FF, 5'd4, 2'b00);
    set_b(1'b1, 32'hF000_0000, 5'd8, 2'b10);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_id", 32'(bus.res_id), ids[i]);
    end
    check("rr_b_data", bus.res_data, 32'hFFF0_0000);

    // Backpressure for three cycles
    bus.res_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_a_rdy", 32'(bus.a_ready), 32'd0);
      check("stall_b_rdy", 32'(bus.b_ready), 32'd0);
      step();
      check("stall_data", bus.res_data, 32'hFFF0_0000);
      check("stall_id", 32'(bus.res_id), 32'd1);
    end
    bus.res_ready = 1'b1;
    #1;
    check("resume_a_rdy", 32'(bus.a_ready), 32'd1);
    check("resume_b_rdy", 32'(bus.b_ready), 32'd0);
    step();
    check("resume_id", 32'(bus.res_id), 32'd0);
    check("resume_data", bus.res_data, 32'h0000_0FF0);
    set_b(1'b0, '0, '0, '0);

    // Zero shift for each op
    for (int op = 0; op < 4; op++) begin
      set_a(1'b1, 32'hDEAD_BEEF, 5'd0, 2'(op));
      step();
      check("zero_shift", bus.res_data, 32'hDEAD_BEEF);
    end

    // Async reset while full
    check("pre_rst_valid", 32'(bus.res_valid), 32'd1);
    set_b(1'b1, 32'h1234_5678, 5'd3, 2'b01);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.res_valid), 32'd0);
    check("arst_data", bus.res_data, 32'd0);
    check("arst_a_rdy", 32'(bus.a_ready), 32'd0);
    check("arst_b_rdy", 32'(bus.b_ready), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("post_a_rdy", 32'(bus.a_ready), 32'd1);
    check("post_b_rdy", 32'(bus.b_ready), 32'd0);
    step();
    check("post_id", 32'(bus.res_id), 32'd0);
    step();
    check("post_id2", 32'(bus.res_id), 32'd1);
    check("post_data2", bus.res_data, 32'h0246_8ACF);

    set_a(1'b0, '0, '0, '0);
    set_b(1'b0, '0, '0, '0);
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
